// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial adder controller: FSM encodings and default width.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/half_adder.sv
// Combinational half adder cell.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/serial_fa_bit.sv
// One-bit full adder built from two chained half adders and an OR for the carry.
module serial_fa_bit (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic co
);

    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (
        .x (x),
        .y (y),
        .s (s1),
        .c (c1)
    );

    half_adder u_ha1 (
        .x (s1),
        .y (cin),
        .s (s),
        .c (c2)
    );

    assign co = c1 | c2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: sequences one full-adder cell across a WIDTH-bit add,
// LSB first, one bit per clock, with a start/busy/done handshake.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] r_next;
    logic             last;

    serial_fa_bit u_fa (
        .x   (a_sh[0]),
        .y   (b_sh[0]),
        .cin (carry),
        .s   (bit_s),
        .co  (bit_c)
    );

    // The new bit enters at the MSB; going through a WIDTH+1 vector keeps WIDTH=1 legal.
    assign r_next = WIDTH'({bit_s, r_sh} >> 1);
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= r_next;
                    carry <= bit_c;
                    cnt   <= cnt + CNT_W'(1);
                    // Only the final edge publishes, so sum/cout never show partial results.
                    if (last) begin
                        sum   <= r_next;
                        cout  <= bit_c;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller. Sequences a single 1-bit full-adder datapath across a WIDTH-bit add, one bit per clock, LSB first.
- The datapath is two chained `half_adder` cells plus an OR gate for the carry. The controller owns the operand shift registers, the carry flop, the bit counter and a start/busy/done handshake.
- Used wherever area matters more than latency, in place of a WIDTH-bit ripple adder.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1 to 32.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new add; sampled only when not busy.
- a  input  WIDTH  operand A; sampled on the accepted start edge.
- b  input  WIDTH  operand B; sampled on the accepted start edge.
- busy  output  1  high while an add is in progress.
- done  output  1  one-cycle pulse; result is valid.
- sum  output  WIDTH  result, registered; holds its value until the next result is produced.
- cout  output  1  carry out of the MSB, registered; holds like sum.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry and counter are all cleared.
  - rst takes priority over start.
- FSM states: IDLE, RUN, DONE. Encoding comes from the shared constants file.
- IDLE:
  - If start=1 at an edge: load a_sh<=a, b_sh<=b, carry<=0, cnt<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, on each edge:
  - Bit computation through two half adders: s1=a_sh[0]^b_sh[0], c1=a_sh[0]&b_sh[0]; bit=s1^carry, c2=s1&carry.
  - carry<=c1|c2.
  - The result shift register shifts right with bit inserted at the MSB.
  - a_sh and b_sh shift right with 0 fill.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge, the shift is the final one. Also load sum<=final shifted value and cout<=c1|c2, then go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - start=1 at the edge is accepted, with the same actions as in IDLE, and the FSM goes directly to RUN.
  - Otherwise go to IDLE.
- Outputs are Moore-decoded from registered state: busy=(state==RUN), done=(state==DONE).
- Latency: start accepted at edge 0. busy is high for cycles 1..WIDTH. done is high in cycle WIDTH+1. sum/cout are valid from cycle WIDTH+1.
- Throughput: one add per WIDTH+1 cycles, achieved by back-to-back starts in the DONE cycle.
- start while busy=1 is ignored. It is not queued, and a/b are not resampled.
- a and b may change freely after the accepted start edge.
- sum and cout update only on the final RUN edge. They never show partial results, and they hold through IDLE and through a subsequent RUN.
- Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of a+b.
- WIDTH=1: RUN lasts exactly one cycle.
- Reset in RUN or DONE aborts the add and applies the reset values listed above; done is not asserted.

Decomposition:
- Shared constants file: FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH.
- One natural sub-module, `serial_fa_bit`: a combinational 1-bit full adder built from two `half_adder` instances plus an OR gate. Ports: x, y, cin, s, co.
- The controller instantiates `serial_fa_bit` once and keeps all sequential logic local.

Test Plan:
- WIDTH=8, a=8'h0F, b=8'h01, start pulsed at cycle 0 → busy high for cycles 1–8; done in cycle 9 with sum=8'h10, cout=0.
- WIDTH=8, a=8'hFF, b=8'h01 → done in cycle 9 with sum=8'h00, cout=1. Also a=8'hFF, b=8'hFF → sum=8'hFE, cout=1.
- Start 8'h12+8'h34, then pulse start with a=8'hAA, b=8'h55 in cycle 4 → the second start is ignored; result is sum=8'h46, cout=0; no second done.
- Back-to-back: start held high continuously with a=8'h80, b=8'h80, then 8'h01+8'h02 presented during the DONE cycle → done in cycle 9 (sum=8'h00, cout=1) and in cycle 18 (sum=8'h03, cout=0).
- rst=1 asserted in cycle 5 of an add → from the next cycle busy=0, done=0, sum=0, cout=0; no done pulse; a fresh start afterwards produces the correct result.
- WIDTH=1 build: a=1, b=1 → busy in cycle 1, done in cycle 2 with sum=0, cout=1. Plus a random sweep of 1000 operand pairs checked against a+b.
